fetch_unit: RTL and testbench

- Instruction fetch stage: owns the PC, drives the read port of the 32-word instruction memory (imem) and presents instruction/PC pairs to decode over a valid/ready handshake.
- Handles decode back-pressure, branch/jump redirects and misaligned-target trapping.
- Sits between the branch-resolution logic upstream and imem/decode downstream.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_pc_reg.sv | 55 +++++
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage:
//     - state_e         : fetch FSM states (IDLE, RUN, ERR)
//     - INSTR_BYTES     : PC increment per sequential fetch
//     - NOP_INSTR       : canonical RV32 NOP (addi x0,x0,0)
//     - RESET_PC_DEFAULT: default PC loaded at reset
//     - sat_inc32()     : saturating 32-bit increment for the perf counters
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
//   Holds the next PC to be fetched. Loads a redirect target when it is
//   word-aligned, otherwise advances by INSTR_BYTES when told to issue.
//   Ports:
//     clk, rst_n       : clock, synchronous active-low reset
//     inc_en           : advance PC by one instruction (issue)
//     load_en          : redirect request accepted this cycle
//     load_pc          : redirect target
//     fetch_pc         : current fetch PC
//     load_misaligned  : load_pc is not word-aligned (combinational)
// -----------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_en,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] fetch_pc,
  output logic            load_misaligned
);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;

  assign load_misaligned = |load_pc[1:0];

  // A misaligned target leaves the PC untouched; the caller traps instead.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (load_en) begin
      if (!load_misaligned) begin
        fetch_pc_d = load_pc;
      end
    end else if (inc_en) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the PC, drives the read port of a 32-word
//   synchronous-read imem (1-cycle latency) and presents instr/PC pairs to
//   decode over a valid/ready handshake. Handles decode back-pressure,
//   redirects and misaligned-redirect trapping (sticky, cleared by reset).
//   Optional macro FETCH_PERF_CNT_EN adds saturating stall/redirect counters;
//   without it stall_cnt/redirect_cnt read 0 and no counter flops exist.
//   Ports:
//     clk, rst_n                 : clock, synchronous active-low reset
//     fetch_en                   : permit new fetches
//     redirect_valid/redirect_pc : single-cycle redirect request and target
//     imem_addr/imem_rw/
//     imem_data_in/imem_data_out : imem port (read-only use)
//     if_valid/id_ready          : handshake to decode
//     if_instr/if_pc             : instruction and its PC
//     misaligned_err             : sticky misaligned-redirect flag
//     stall_cnt/redirect_cnt     : performance counters
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 5,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_rw,
  output logic [XLEN-1:0]    imem_data_in,
  input  logic [XLEN-1:0]    imem_data_out,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    if_instr,
  output logic [XLEN-1:0]    if_pc,
  output logic               misaligned_err,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        redirect_cnt
);

  state_e          state_q, state_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            misaligned_err_q, misaligned_err_d;

  logic            stall;
  logic            issue;
  logic            redirect_accept;
  logic [XLEN-1:0] fetch_pc;
  logic            target_misaligned;

  // Once trapped, redirects are ignored until reset.
  assign redirect_accept = redirect_valid && (state_q != ST_ERR);
  assign stall           = if_valid_q && !id_ready;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .inc_en          (issue),
    .load_en         (redirect_accept),
    .load_pc         (redirect_pc),
    .fetch_pc        (fetch_pc),
    .load_misaligned (target_misaligned)
  );

  always_comb begin
    state_d          = state_q;
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    misaligned_err_d = misaligned_err_q;
    issue            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if_valid_d = 1'b0;
        if (fetch_en) begin
          issue   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (fetch_en) begin
            issue = 1'b1;
          end else begin
            if_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if_valid_d = 1'b0;
      end
      default: begin
        if_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Redirect beats stall and fetch_en; it drops any wrong-path instruction.
    if (redirect_accept) begin
      issue      = 1'b0;
      if_valid_d = 1'b0;
      if (target_misaligned) begin
        misaligned_err_d = 1'b1;
        state_d          = ST_ERR;
      end else begin
        state_d = fetch_en ? ST_RUN : ST_IDLE;
      end
    end

    if (issue) begin
      if_valid_d = 1'b1;
      if_pc_d    = fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      if_valid_q       <= 1'b0;
      if_pc_q          <= '0;
      misaligned_err_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      misaligned_err_q <= misaligned_err_d;
    end
  end

  // While stalled, re-read the held instruction so imem_data_out stays put.
  assign imem_addr    = stall ? if_pc_q[IMEM_AW+1:2] : fetch_pc[IMEM_AW+1:2];
  assign imem_rw      = 1'b1;
  assign imem_data_in = '0;

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_valid_q ? imem_data_out : '0;
  assign misaligned_err = misaligned_err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    stall_cnt_d    = stall ? sat_inc32(stall_cnt_q) : stall_cnt_q;
    redirect_cnt_d = redirect_accept ? sat_inc32(redirect_cnt_q) : redirect_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  assign stall_cnt    = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit: directed vector table, hand-written
//   corner sequences (wrap, fetch_en pause, misaligned trap) and randomized
//   traffic checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  imem_addr;
  logic        imem_rw;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misaligned_err;
  logic [31:0] stall_cnt;
  logic [31:0] redirect_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rw        (imem_rw),
    .imem_data_in   (imem_data_in),
    .imem_data_out  (imem_data_out),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misaligned_err (misaligned_err),
    .stall_cnt      (stall_cnt),
    .redirect_cnt   (redirect_cnt)
  );

  // Synchronous-read instruction memory, 1-cycle latency.
  always @(posedge clk) imem_data_out <= mem[imem_addr];

  // Reference model: what decode should see. m_next is the next address the
  // stage owes decode; m_valid/m_pc describe the instruction on offer.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic        m_err;
  logic [31:0] m_stalls;
  logic [31:0] m_redirs;

  task automatic model_reset();
    m_valid = 1'b0; m_pc = 32'h0; m_next = 32'h0; m_err = 1'b0;
    m_stalls = 32'h0; m_redirs = 32'h0;
  endtask

  task automatic model_edge(input logic rn, input logic fe, input logic rdy,
                            input logic rv, input logic [31:0] rpc);
    logic held;
    if (!rn) begin
      model_reset();
      return;
    end
    held = m_valid && !rdy;
    if (held && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
    if (m_err) begin
      m_valid = 1'b0;
    end else if (rv) begin
      if (m_redirs != 32'hFFFF_FFFF) m_redirs = m_redirs + 1;
      m_valid = 1'b0;
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
      else m_next = rpc;
    end else if (held) begin
      // decode has not taken the instruction yet; offer it again
    end else if (fe) begin
      m_valid = 1'b1;
      m_pc    = m_next;
      m_next  = m_next + 32'd4;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [31:0] e_instr;
    logic [4:0]  e_addr;
    logic [31:0] e_sc, e_rc;
    e_instr = m_valid ? mem[m_pc[6:2]] : 32'h0;
    e_addr  = (m_valid && !id_ready) ? m_pc[6:2] : m_next[6:2];
`ifdef FETCH_PERF_CNT_EN
    e_sc = m_stalls; e_rc = m_redirs;
`else
    e_sc = 32'h0; e_rc = 32'h0;
`endif
    chk("model_valid", {31'h0, if_valid}, {31'h0, m_valid});
    chk("model_pc", if_pc, m_pc);
    chk("model_instr", if_instr, e_instr);
    chk("model_addr", {27'h0, imem_addr}, {27'h0, e_addr});
    chk("model_err", {31'h0, misaligned_err}, {31'h0, m_err});
    chk("model_stall_cnt", stall_cnt, e_sc);
    chk("model_redirect_cnt", redirect_cnt, e_rc);
    chk("imem_rw", {31'h0, imem_rw}, 32'h1);
    chk("imem_data_in", imem_data_in, 32'h0);
  endtask

  // One clock: model consumes the inputs the DUT samples, outputs checked #1 later.
  task automatic step();
    @(posedge clk);
    model_edge(rst_n, fetch_en, id_ready, redirect_valid, redirect_pc);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_scnt;
    logic [31:0] exp_rcnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + (i * 32'h0001_0101);
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0016_8693;
    mem[2]  = 32'h0000_0013;
    mem[16] = 32'h0400_0513;

    //        fe    rdy   rv    rpc      valid pc       instr          scnt rcnt
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h0050_0093, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0016_8693, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0016_8693, 1, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0016_8693, 2, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0016_8693, 3, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0000_0013, 3, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0000_0013, 4, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h08, 32'h0000_0000, 5, 1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h0400_0513, 5, 1};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, mem[17],       5, 1};

    model_reset();
    rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    step();
    step();
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_err", {31'h0, misaligned_err}, 32'h0);
    chk("rst_addr", {27'h0, imem_addr}, 32'h0);

    // Directed vector table: sequential fetch, stall, redirect during stall.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch_en = vecs[i].fe; id_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      step();
      $display("vec %0d: valid=%0b pc=%h instr=%h", i, if_valid, if_pc, if_instr);
      chk("vec_valid", {31'h0, if_valid}, {31'h0, vecs[i].exp_valid});
      chk("vec_pc", if_pc, vecs[i].exp_pc);
      chk("vec_instr", if_instr, vecs[i].exp_instr);
`ifdef FETCH_PERF_CNT_EN
      chk("vec_stall_cnt", stall_cnt, vecs[i].exp_scnt);
      chk("vec_redirect_cnt", redirect_cnt, vecs[i].exp_rcnt);
`else
      chk("vec_stall_cnt", stall_cnt, 32'h0);
      chk("vec_redirect_cnt", redirect_cnt, 32'h0);
`endif
    end
    redirect_valid = 1'b0;

    // Wrap: fetch from 0x7C, next issue is 0x80 which maps to word 0.
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h7C;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc7c", if_pc, 32'h7C);
    chk("wrap_addr", {27'h0, imem_addr}, 32'h0);
    step();
    $display("wrap: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    chk("wrap_pc80", if_pc, 32'h80);
    chk("wrap_instr", if_instr, mem[0]);

    // Pause fetch: address freezes, resume without skipping.
    fetch_en = 1'b0;
    step();
    chk("pause_valid", {31'h0, if_valid}, 32'h0);
    chk("pause_addr0", {27'h0, imem_addr}, 32'h1);
    step();
    chk("pause_addr1", {27'h0, imem_addr}, 32'h1);
    fetch_en = 1'b1;
    step();
    $display("resume: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    chk("resume_pc", if_pc, 32'h84);
    chk("resume_instr", if_instr, mem[1]);

    // Misaligned redirect traps until reset.
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    chk("mis_err", {31'h0, misaligned_err}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mis_valid_low", {31'h0, if_valid}, 32'h0);
      chk("mis_err_sticky", {31'h0, misaligned_err}, 32'h1);
    end
    rst_n = 1'b0;
    step();
    chk("mis_rst_err", {31'h0, misaligned_err}, 32'h0);
    rst_n = 1'b1;
    step();
    $display("post-trap: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    chk("mis_resume_valid", {31'h0, if_valid}, 32'h1);
    chk("mis_resume_pc", if_pc, 32'h0);
    chk("mis_resume_instr", if_instr, mem[0]);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      if (m_err && $urandom_range(0, 15) == 0) rst_n = 1'b0;
      fetch_en       = ($urandom_range(0, 7) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 49) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
